// File: rtl/vfd_ramp_ctrl.sv
// vfd_ramp_ctrl: soft-start / soft-stop sequencer for the VFD modulation path.
// Slews the NCO phase increment toward a programmed target in bounded steps
// at a programmable interval, ramps back to zero on stop, pulses recalc to the
// fixed driver whenever the increment changes and gates the driver enable.
module vfd_ramp_ctrl #(
  parameter int INC_BITS  = 24,
  parameter int STEP_BITS = 16,
  parameter int TICK_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [INC_BITS-1:0]  target_inc,
  input  logic [STEP_BITS-1:0] step_inc,
  input  logic [TICK_BITS-1:0] step_ticks,
  output logic [INC_BITS-1:0]  phase_inc,
  output logic                 recalc,
  output logic                 drv_en,
  output logic                 busy,
  output logic                 at_target
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP      = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [TICK_BITS-1:0] cnt, cnt_nxt, cnt_load;
  logic [INC_BITS-1:0]  phase_nxt;
  logic [INC_BITS-1:0]  step_s;
  logic                 recalc_nxt;

  // Zero step size and zero interval both behave as 1.
  assign step_s   = (step_inc == '0) ? INC_BITS'(1) : INC_BITS'(step_inc);
  assign cnt_load = (step_ticks == '0) ? '0 : step_ticks - TICK_BITS'(1);

  // One step toward tgt, clamped so the target is never overshot.
  // The extra bit keeps the sum/difference from wrapping.
  function automatic logic [INC_BITS-1:0] step_toward(
    input logic [INC_BITS-1:0] cur,
    input logic [INC_BITS-1:0] tgt,
    input logic [INC_BITS-1:0] s
  );
    logic [INC_BITS:0] sum;
    logic [INC_BITS:0] diff;
    sum  = {1'b0, cur} + {1'b0, s};
    diff = {1'b0, cur} - {1'b0, s};
    if (cur < tgt)
      step_toward = (sum > {1'b0, tgt}) ? tgt : sum[INC_BITS-1:0];
    else if (cur > tgt)
      step_toward = (diff[INC_BITS] || (diff[INC_BITS-1:0] < tgt)) ? tgt
                                                                   : diff[INC_BITS-1:0];
    else
      step_toward = cur;
  endfunction

  // One step toward zero, saturating at zero.
  function automatic logic [INC_BITS-1:0] step_down(
    input logic [INC_BITS-1:0] cur,
    input logic [INC_BITS-1:0] s
  );
    step_down = (cur < s) ? '0 : cur - s;
  endfunction

  // Next-state, next increment and interval counter; stop outranks start.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase_inc;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = RAMP;
          cnt_nxt   = cnt_load;
        end
      end
      RAMP: begin
        if (stop) begin
          state_nxt = RAMP_DOWN;
          cnt_nxt   = cnt_load;
        end else if (cnt == '0) begin
          cnt_nxt = cnt_load;
          if (phase_inc == target_inc)
            state_nxt = HOLD;
          else
            phase_nxt = step_toward(phase_inc, target_inc, step_s);
        end else begin
          cnt_nxt = cnt - TICK_BITS'(1);
        end
      end
      HOLD: begin
        if (stop) begin
          state_nxt = RAMP_DOWN;
          cnt_nxt   = cnt_load;
        end else if (target_inc != phase_inc) begin
          state_nxt = RAMP;
          cnt_nxt   = cnt_load;
        end
      end
      RAMP_DOWN: begin
        if (start && !stop) begin
          state_nxt = RAMP;
          cnt_nxt   = cnt_load;
        end else if (cnt == '0) begin
          cnt_nxt = cnt_load;
          if (phase_inc == '0)
            state_nxt = IDLE;
          else
            phase_nxt = step_down(phase_inc, step_s);
        end else begin
          cnt_nxt = cnt - TICK_BITS'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
    recalc_nxt = (phase_nxt != phase_inc);
  end

  // State, increment, counter and decoded outputs, all registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_inc <= '0;
      cnt       <= '0;
      recalc    <= 1'b0;
      drv_en    <= 1'b0;
      busy      <= 1'b0;
      at_target <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase_inc <= phase_nxt;
      cnt       <= cnt_nxt;
      recalc    <= recalc_nxt;
      drv_en    <= (state_nxt != IDLE);
      busy      <= (state_nxt == RAMP) || (state_nxt == RAMP_DOWN);
      at_target <= (state_nxt == HOLD);
    end
  end

endmodule
